// File: rtl/if_fetch.sv
// Instruction fetch stage: PC register, single-outstanding imem read, valid/ready hand-off to decode.
// Downstream redirects replace the PC and squash whatever fetch is in flight.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam logic [1:0] S_REQ   = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic        r_valid;
    logic        w_valid_next;
    logic [31:0] r_inst;
    logic [31:0] w_inst_next;
    logic [31:0] r_id_pc;
    logic [31:0] w_id_pc_next;
    logic [31:0] w_redirect_pc;
    logic        w_unused;

    assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
    assign w_unused      = ^redirect_pc[1:0];

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_valid_next = r_valid;
        w_inst_next  = r_inst;
        w_id_pc_next = r_id_pc;
        if (redirect) begin
            // Redirect wins over every other event; an outstanding read must still be drained.
            w_pc_next    = w_redirect_pc;
            w_valid_next = 1'b0;
            case (r_state)
                S_REQ:   w_state_next = S_DRAIN;
                S_WAIT:  w_state_next = imem_rvalid ? S_REQ : S_DRAIN;
                S_HOLD:  w_state_next = S_REQ;
                default: w_state_next = imem_rvalid ? S_REQ : S_DRAIN;
            endcase
        end else begin
            case (r_state)
                S_REQ: begin
                    w_state_next = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        w_inst_next  = imem_rdata;
                        w_id_pc_next = r_pc;
                        w_valid_next = 1'b1;
                        w_state_next = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (r_valid && id_ready) begin
                        w_pc_next    = r_pc + 32'd4;
                        w_valid_next = 1'b0;
                        w_state_next = S_REQ;
                    end
                end
                default: begin
                    if (imem_rvalid) begin
                        w_state_next = S_REQ;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_REQ;
            r_pc    <= RESET_PC;
            r_valid <= 1'b0;
            r_inst  <= NOP;
            r_id_pc <= RESET_PC;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_valid <= w_valid_next;
            r_inst  <= w_inst_next;
            r_id_pc <= w_id_pc_next;
        end
    end

    // Reset holds the FSM in S_REQ, so the strobe is masked while rst is high.
    assign imem_req  = (r_state == S_REQ) && !rst;
    assign imem_addr = r_pc;
    assign id_valid  = r_valid;
    assign id_inst   = r_inst;
    assign id_pc     = r_id_pc;
    assign id_pc4    = r_id_pc + 32'd4;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: behavioural imem with variable latency, fetch scoreboard,
// cycle table after reset and directed redirect / stall / wrap / reset sequences.
module tb_if_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic        redirect;
    logic [31:0] redirect_pc;

    if_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_inst     (id_inst),
        .id_pc       (id_pc),
        .id_pc4      (id_pc4),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } fetch_t;

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
    } vec_t;

    fetch_t      sb_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          lat = 1;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = 32'h0;
    logic [31:0] exp_pc;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string name, input int max);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (imem_req) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: no imem_req within %0d cycles", name, max);
        end
    endtask

    task automatic wait_valid(input string name, input int max);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (id_valid) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: no id_valid within %0d cycles", name, max);
        end
    endtask

    // Instruction memory: request seen in cycle k answers in cycle k+lat; cleared by rst.
    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            imem_rvalid = 1'b0;
            if (!rst && mem_cnt > 0) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = word_at(mem_addr);
                end
            end
            @(negedge clk);
            if (rst) begin
                mem_cnt     = 0;
                imem_rvalid = 1'b0;
            end else if (imem_req) begin
                check("req_while_outstanding", 32'(mem_cnt), 32'd0);
                mem_cnt  = lat;
                mem_addr = imem_addr;
            end
        end
    end

    // Scoreboard: every request predicts its fetch; accepted instructions are popped and compared.
    initial begin
        fetch_t e;
        exp_pc = RESET_PC;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb_q.delete();
                exp_pc = RESET_PC;
            end else begin
                if (imem_req) begin
                    check("imem_addr", imem_addr, exp_pc);
                    sb_q.push_back('{addr: exp_pc, data: word_at(exp_pc)});
                end
                if (redirect) begin
                    sb_q.delete();
                    exp_pc = {redirect_pc[31:2], 2'b00};
                end else if (id_valid && id_ready) begin
                    if (sb_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL accept_unexpected: id_pc %08h accepted, none expected", id_pc);
                    end else begin
                        e = sb_q.pop_front();
                        check("acc_id_pc", id_pc, e.addr);
                        check("acc_id_inst", id_inst, e.data);
                        check("acc_id_pc4", id_pc4, e.addr + 32'd4);
                        exp_pc = e.addr + 32'd4;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[9];
        int   stale;

        tbl[0] = '{req: 1'b1, addr: 32'h0, valid: 1'b0, pc: 32'h0};
        tbl[1] = '{req: 1'b0, addr: 32'h0, valid: 1'b0, pc: 32'h0};
        tbl[2] = '{req: 1'b0, addr: 32'h0, valid: 1'b1, pc: 32'h0};
        tbl[3] = '{req: 1'b1, addr: 32'h4, valid: 1'b0, pc: 32'h0};
        tbl[4] = '{req: 1'b0, addr: 32'h4, valid: 1'b0, pc: 32'h0};
        tbl[5] = '{req: 1'b0, addr: 32'h4, valid: 1'b1, pc: 32'h4};
        tbl[6] = '{req: 1'b1, addr: 32'h8, valid: 1'b0, pc: 32'h4};
        tbl[7] = '{req: 1'b0, addr: 32'h8, valid: 1'b0, pc: 32'h4};
        tbl[8] = '{req: 1'b0, addr: 32'h8, valid: 1'b1, pc: 32'h8};

        rst         = 1'b1;
        id_ready    = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        lat         = 1;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_imem_addr", imem_addr, RESET_PC);
        check("rst_id_valid", 32'(id_valid), 32'd0);
        check("rst_id_inst", id_inst, 32'h0000_0013);
        check("rst_id_pc", id_pc, RESET_PC);
        check("rst_id_pc4", id_pc4, RESET_PC + 32'd4);

        // Latency 1, always ready: REQ/WAIT/HOLD per instruction
        step();
        rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check($sformatf("tbl%0d_req", i), 32'(imem_req), 32'(tbl[i].req));
            check($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].addr);
            check($sformatf("tbl%0d_valid", i), 32'(id_valid), 32'(tbl[i].valid));
            check($sformatf("tbl%0d_id_pc", i), id_pc, tbl[i].pc);
        end

        // Decode stalls in HOLD for 5+ cycles
        step();
        id_ready = 1'b0;
        wait_valid("stall_valid", 10);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 32'(id_valid), 32'd1);
            check("stall_id_pc", id_pc, 32'hC);
            check("stall_id_inst", id_inst, word_at(32'hC));
            check("stall_no_req", 32'(imem_req), 32'd0);
            @(negedge clk);
        end
        step();
        id_ready = 1'b1;
        wait_req("stall_release", 8);
        check("stall_next_addr", imem_addr, 32'h10);

        // Redirect while waiting on a slow response
        step();
        lat = 3;
        wait_req("wait_lat3_req", 12);
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_1003;
        step();
        redirect = 1'b0;
        stale    = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (id_valid) stale++;
            if (imem_req) break;
        end
        check("drain_stale_valid", 32'(stale), 32'd0);
        check("drain_req", 32'(imem_req), 32'd1);
        check("drain_next_addr", imem_addr, 32'h0000_1000);

        // Redirect in HOLD together with id_ready
        step();
        lat      = 1;
        id_ready = 1'b0;
        wait_valid("hold_redir_valid", 12);
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0080;
        id_ready    = 1'b1;
        step();
        redirect = 1'b0;
        @(negedge clk);
        check("hold_redir_valid_drop", 32'(id_valid), 32'd0);
        check("hold_redir_req", 32'(imem_req), 32'd1);
        check("hold_redir_addr", imem_addr, 32'h0000_0080);

        // PC wrap at the top of the address space
        step();
        id_ready = 1'b0;
        wait_valid("wrap_pre_valid", 10);
        step();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        step();
        redirect = 1'b0;
        wait_valid("wrap_valid", 10);
        check("wrap_id_pc", id_pc, 32'hFFFF_FFFC);
        check("wrap_id_pc4", id_pc4, 32'h0000_0000);
        check("wrap_id_inst", id_inst, word_at(32'hFFFF_FFFC));
        step();
        id_ready = 1'b1;
        wait_req("wrap_next_req", 8);
        check("wrap_next_addr", imem_addr, 32'h0000_0000);

        // Reset asserted in WAIT
        step();
        lat = 3;
        wait_req("rst_wait_req", 12);
        check("rst_wait_req_addr", imem_addr, 32'h4);
        step();
        rst = 1'b1;
        #1;
        check("midrst_imem_req", 32'(imem_req), 32'd0);
        check("midrst_imem_addr", imem_addr, RESET_PC);
        check("midrst_id_valid", 32'(id_valid), 32'd0);
        check("midrst_id_inst", id_inst, 32'h0000_0013);
        check("midrst_id_pc", id_pc, RESET_PC);
        check("midrst_id_pc4", id_pc4, RESET_PC + 32'd4);
        step();
        step();
        rst = 1'b0;
        lat = 1;
        wait_req("restart_req", 2);
        check("restart_addr", imem_addr, RESET_PC);
        step();
        wait_req("restart_req2", 8);
        check("restart_addr2", imem_addr, RESET_PC + 32'd4);

        step();
        step();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
